// File: rtl/iq_correction_sat_if.sv
// Sample stream bundle for the IQ corrector: one sample in, one corrected sample out.
// Handshake: in_valid qualifies IQ_i_* on the cycle it is high; there is no ready/back-pressure,
// and out_valid qualifies IQ_o_* exactly four cycles after the matching in_valid.
interface iq_correction_sat_if #(
  parameter int INPUT_WIDTH  = 14,
  parameter int OUTPUT_WIDTH = 16
);
  logic                           in_valid;
  logic signed [INPUT_WIDTH-1:0]  IQ_i_real;
  logic signed [INPUT_WIDTH-1:0]  IQ_i_imag;
  logic                           out_valid;
  logic signed [OUTPUT_WIDTH-1:0] IQ_o_real;
  logic signed [OUTPUT_WIDTH-1:0] IQ_o_imag;

  modport master (
    output in_valid, IQ_i_real, IQ_i_imag,
    input  out_valid, IQ_o_real, IQ_o_imag
  );

  modport slave (
    input  in_valid, IQ_i_real, IQ_i_imag,
    output out_valid, IQ_o_real, IQ_o_imag
  );
endinterface

// File: rtl/iq_correction_sat.sv
// Four-stage IQ offset + 2x2 matrix corrector with round-half-up, output saturation,
// a saturation monitor, atomic double-buffered coefficient loads and an equal-latency bypass.
module iq_correction_sat #(
  parameter int INPUT_WIDTH     = 14,
  parameter int OUTPUT_WIDTH    = 16,
  parameter int GAIN_WIDTH      = 24,
  parameter int GAIN_WIDTH_FRAC = 12,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  iq_correction_sat_if.slave            s,
  input  logic signed [INPUT_WIDTH-1:0] Bvect1,
  input  logic signed [INPUT_WIDTH-1:0] Bvect2,
  input  logic signed [GAIN_WIDTH-1:0]  Amat11,
  input  logic signed [GAIN_WIDTH-1:0]  Amat12,
  input  logic signed [GAIN_WIDTH-1:0]  Amat21,
  input  logic signed [GAIN_WIDTH-1:0]  Amat22,
  input  logic                          coef_load,
  input  logic                          bypass,
  input  logic                          sat_clear,
  output logic                          sat_flag,
  output logic [COUNT_WIDTH-1:0]        sat_count
);
  localparam int IW   = INPUT_WIDTH;
  localparam int OW   = OUTPUT_WIDTH;
  localparam int GW   = GAIN_WIDTH;
  localparam int FRAC = GAIN_WIDTH_FRAC;
  localparam int XW   = IW + 1;       // offset-corrected sample
  localparam int PW   = XW + GW;      // single product
  localparam int SW   = PW + 1;       // sum of two products
  localparam int RW   = SW - FRAC;    // rounded, rescaled sum
  localparam int CW   = RW + OW;      // comparison width for the saturator

  localparam logic signed [GW-1:0] UNITY   = {{(GW-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [SW-1:0] RND     = {{(SW-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [CW-1:0] SAT_MAX = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN = {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  // Active coefficient set
  logic signed [IW-1:0] act_b1, act_b2;
  logic signed [GW-1:0] act_a11, act_a12, act_a21, act_a22;

  // Stage 1
  logic                 s1_vld, s1_byp;
  logic signed [XW-1:0] s1_re_c, s1_im_c;
  logic signed [IW-1:0] s1_raw_re, s1_raw_im;
  logic signed [GW-1:0] s1_a11, s1_a12, s1_a21, s1_a22;

  // Stage 2
  logic                 s2_vld, s2_byp;
  logic signed [PW-1:0] s2_p11, s2_p12, s2_p21, s2_p22;
  logic signed [IW-1:0] s2_raw_re, s2_raw_im;

  // Stage 3
  logic                 s3_vld, s3_byp;
  logic signed [RW-1:0] s3_re, s3_im;
  logic signed [IW-1:0] s3_raw_re, s3_raw_im;

  logic signed [SW-1:0] sum_re, sum_im;
  logic signed [CW-1:0] sel_re, sel_im;
  logic [OW:0]          sat_re, sat_im;
  logic                 sat_s, sat_ev;

  // Returns {saturated, clamped value}
  function automatic logic [OW:0] saturate(input logic signed [CW-1:0] v);
    if (v > SAT_MAX)      return {1'b1, SAT_MAX[OW-1:0]};
    else if (v < SAT_MIN) return {1'b1, SAT_MIN[OW-1:0]};
    else                  return {1'b0, v[OW-1:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      act_b1  <= '0;
      act_b2  <= '0;
      act_a11 <= UNITY;
      act_a12 <= '0;
      act_a21 <= '0;
      act_a22 <= UNITY;
    end else if (coef_load) begin
      act_b1  <= Bvect1;
      act_b2  <= Bvect2;
      act_a11 <= Amat11;
      act_a12 <= Amat12;
      act_a21 <= Amat21;
      act_a22 <= Amat22;
    end
  end

  // The stage-1 copy reads the active set before a same-cycle load lands in it,
  // so a sample accepted alongside coef_load still sees the old B and A together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_byp    <= 1'b0;
      s1_re_c   <= '0;
      s1_im_c   <= '0;
      s1_raw_re <= '0;
      s1_raw_im <= '0;
      s1_a11    <= UNITY;
      s1_a12    <= '0;
      s1_a21    <= '0;
      s1_a22    <= UNITY;
    end else begin
      s1_vld    <= s.in_valid;
      s1_byp    <= bypass;
      s1_re_c   <= XW'(s.IQ_i_real) + XW'(act_b1);
      s1_im_c   <= XW'(s.IQ_i_imag) + XW'(act_b2);
      s1_raw_re <= s.IQ_i_real;
      s1_raw_im <= s.IQ_i_imag;
      s1_a11    <= act_a11;
      s1_a12    <= act_a12;
      s1_a21    <= act_a21;
      s1_a22    <= act_a22;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld    <= 1'b0;
      s2_byp    <= 1'b0;
      s2_p11    <= '0;
      s2_p12    <= '0;
      s2_p21    <= '0;
      s2_p22    <= '0;
      s2_raw_re <= '0;
      s2_raw_im <= '0;
    end else begin
      s2_vld    <= s1_vld;
      s2_byp    <= s1_byp;
      s2_p11    <= PW'(s1_a11) * PW'(s1_re_c);
      s2_p12    <= PW'(s1_a12) * PW'(s1_im_c);
      s2_p21    <= PW'(s1_a21) * PW'(s1_re_c);
      s2_p22    <= PW'(s1_a22) * PW'(s1_im_c);
      s2_raw_re <= s1_raw_re;
      s2_raw_im <= s1_raw_im;
    end
  end

  always_comb begin
    sum_re = SW'(s2_p11) + SW'(s2_p12) + RND;
    sum_im = SW'(s2_p21) + SW'(s2_p22) + RND;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_vld    <= 1'b0;
      s3_byp    <= 1'b0;
      s3_re     <= '0;
      s3_im     <= '0;
      s3_raw_re <= '0;
      s3_raw_im <= '0;
    end else begin
      s3_vld    <= s2_vld;
      s3_byp    <= s2_byp;
      s3_re     <= RW'(sum_re >>> FRAC);
      s3_im     <= RW'(sum_im >>> FRAC);
      s3_raw_re <= s2_raw_re;
      s3_raw_im <= s2_raw_im;
    end
  end

  // Bypass shares the saturator so a narrow output still clamps, but never counts.
  always_comb begin
    sel_re = s3_byp ? CW'(s3_raw_re) : CW'(s3_re);
    sel_im = s3_byp ? CW'(s3_raw_im) : CW'(s3_im);
    sat_re = saturate(sel_re);
    sat_im = saturate(sel_im);
    sat_s  = !s3_byp && (sat_re[OW] || sat_im[OW]);
    sat_ev = s3_vld && sat_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s.out_valid <= 1'b0;
      s.IQ_o_real <= '0;
      s.IQ_o_imag <= '0;
    end else begin
      s.out_valid <= s3_vld;
      s.IQ_o_real <= sat_re[OW-1:0];
      s.IQ_o_imag <= sat_im[OW-1:0];
    end
  end

  // A clear coinciding with an event leaves exactly that one event recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag  <= 1'b0;
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_flag  <= sat_ev;
      sat_count <= sat_ev ? COUNT_WIDTH'(1) : '0;
    end else if (sat_ev) begin
      sat_flag <= 1'b1;
      if (sat_count != '1) sat_count <= sat_count + COUNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_iq_correction_sat.sv
// Bench for iq_correction_sat: directed scenarios plus random traffic against an arithmetic
// reference model that predicts each output from the sample, the coefficients and the mode.
module tb_iq_correction_sat;
  localparam int IW   = 14;
  localparam int OW   = 16;
  localparam int GW   = 24;
  localparam int FRAC = 12;
  localparam int CNTW = 16;
  localparam longint UNITY = 4096;
  localparam longint OMAX  = 32767;
  localparam longint OMIN  = -32768;
  localparam longint CMAX  = 65535;

  typedef struct {
    bit valid;
    int re;
    int im;
    bit sat;
  } exp_t;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst = 1'b1;
  logic signed [IW-1:0]   Bvect1 = '0, Bvect2 = '0;
  logic signed [GW-1:0]   Amat11 = '0, Amat12 = '0, Amat21 = '0, Amat22 = '0;
  logic                   coef_load = 1'b0, bypass = 1'b0, sat_clear = 1'b0;
  logic                   sat_flag;
  logic [CNTW-1:0]        sat_count;

  iq_correction_sat_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) ifc ();

  iq_correction_sat #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .GAIN_WIDTH(GW),
    .GAIN_WIDTH_FRAC(FRAC), .COUNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .s(ifc),
    .Bvect1(Bvect1), .Bvect2(Bvect2),
    .Amat11(Amat11), .Amat12(Amat12), .Amat21(Amat21), .Amat22(Amat22),
    .coef_load(coef_load), .bypass(bypass), .sat_clear(sat_clear),
    .sat_flag(sat_flag), .sat_count(sat_count)
  );

  // Driver state
  bit  drv_rst, drv_valid, drv_byp, drv_load, drv_clear;
  int  drv_re, drv_im, drv_b1, drv_b2;
  longint drv_a11, drv_a12, drv_a21, drv_a22;

  // Reference model state
  int     m_b1, m_b2;
  longint m_a11, m_a12, m_a21, m_a22;
  bit     m_flag;
  longint m_cnt;
  exp_t   exp_q[$];
  int     last_re, last_im;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s step %0d got %0d expected %0d", tag, step_no, got, exp);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return v;
  endfunction

  // Corrected value = round_half_up((A * (x + B)) / 2^FRAC), then clamp to the output range.
  function automatic exp_t model(input int re, input int im, input bit byp);
    exp_t e;
    longint vr, vi;
    if (byp) begin
      vr = re;
      vi = im;
    end else begin
      vr = (m_a11 * longint'(re + m_b1) + m_a12 * longint'(im + m_b2) + (UNITY / 2)) >>> FRAC;
      vi = (m_a21 * longint'(re + m_b1) + m_a22 * longint'(im + m_b2) + (UNITY / 2)) >>> FRAC;
    end
    e.valid = 1'b0;
    e.sat   = !byp && (vr != clamp(vr) || vi != clamp(vi));
    e.re    = int'(clamp(vr));
    e.im    = int'(clamp(vi));
    return e;
  endfunction

  task automatic model_reset();
    exp_t z;
    z.valid = 1'b0; z.re = 0; z.im = 0; z.sat = 1'b0;
    exp_q = {};
    for (int i = 0; i < 3; i++) exp_q.push_back(z);
    m_b1 = 0; m_b2 = 0;
    m_a11 = UNITY; m_a12 = 0; m_a21 = 0; m_a22 = UNITY;
    m_flag = 1'b0; m_cnt = 0;
  endtask

  // One clock: drive at negedge, predict, sample #1 after posedge, compare.
  task automatic tick();
    exp_t e, o;
    @(negedge clk);
    rst           = drv_rst;
    ifc.in_valid  = drv_valid;
    ifc.IQ_i_real = IW'(drv_re);
    ifc.IQ_i_imag = IW'(drv_im);
    bypass        = drv_byp;
    coef_load     = drv_load;
    sat_clear     = drv_clear;
    Bvect1        = IW'(drv_b1);
    Bvect2        = IW'(drv_b2);
    Amat11        = GW'(drv_a11);
    Amat12        = GW'(drv_a12);
    Amat21        = GW'(drv_a21);
    Amat22        = GW'(drv_a22);
    if (!drv_rst) begin
      e = model(drv_re, drv_im, drv_byp);
      e.valid = drv_valid;
      exp_q.push_back(e);
      if (drv_load) begin
        m_b1 = drv_b1; m_b2 = drv_b2;
        m_a11 = drv_a11; m_a12 = drv_a12; m_a21 = drv_a21; m_a22 = drv_a22;
      end
    end
    @(posedge clk);
    #1;
    if (drv_rst) begin
      model_reset();
      chk("rst_out_valid", longint'(ifc.out_valid), 0);
      chk("rst_out_real", longint'(ifc.IQ_o_real), 0);
      chk("rst_out_imag", longint'(ifc.IQ_o_imag), 0);
    end else begin
      o = exp_q.pop_front();
      if (drv_clear) begin
        m_flag = 1'b0;
        m_cnt  = 0;
      end
      if (o.valid && o.sat) begin
        m_flag = 1'b1;
        if (m_cnt != CMAX) m_cnt++;
      end
      chk("out_valid", longint'(ifc.out_valid), longint'(o.valid));
      if (o.valid) begin
        chk("out_real", longint'(ifc.IQ_o_real), longint'(o.re));
        chk("out_imag", longint'(ifc.IQ_o_imag), longint'(o.im));
      end
    end
    if (ifc.out_valid) begin
      last_re = int'(ifc.IQ_o_real);
      last_im = int'(ifc.IQ_o_imag);
    end
    chk("sat_flag", longint'(sat_flag), longint'(m_flag));
    chk("sat_count", longint'(sat_count), m_cnt);
    step_no++;
    drv_rst = 1'b0; drv_valid = 1'b0; drv_load = 1'b0; drv_clear = 1'b0;
  endtask

  task automatic send(input int re, input int im);
    drv_valid = 1'b1;
    drv_re = re;
    drv_im = im;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input int b1, input int b2, input longint a11, input longint a12,
                      input longint a21, input longint a22);
    drv_b1 = b1; drv_b2 = b2;
    drv_a11 = a11; drv_a12 = a12; drv_a21 = a21; drv_a22 = a22;
    drv_load = 1'b1;
    tick();
  endtask

  function automatic int srand(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  initial begin
    ifc.in_valid = 1'b0;
    ifc.IQ_i_real = '0;
    ifc.IQ_i_imag = '0;
    drv_byp = 1'b0; drv_re = 0; drv_im = 0;
    drv_b1 = 0; drv_b2 = 0; drv_a11 = 0; drv_a12 = 0; drv_a21 = 0; drv_a22 = 0;
    model_reset();

    // Reset
    drv_rst = 1'b1; tick();
    drv_rst = 1'b1; tick();
    idle(2);

    // Identity after reset
    send(1000, -500);
    idle(4);
    chk("identity_re", last_re, 1000);
    chk("identity_im", last_im, -500);
    chk("identity_flag", longint'(sat_flag), 0);

    // Offset plus rotation
    load(-100, 50, 0, 4096, 4096, 0);
    send(100, 0);
    idle(4);
    chk("rotate_re", last_re, 50);
    chk("rotate_im", last_im, 0);

    // Round half up
    load(0, 0, 2048, 0, 0, 2048);
    send(3, 1);
    idle(4);
    chk("round_pos_re", last_re, 2);
    chk("round_pos_im", last_im, 1);
    send(-3, -1);
    idle(4);
    chk("round_neg_re", last_re, -1);
    chk("round_neg_im", last_im, 0);

    // Saturation, then clear coinciding with another saturating output
    load(0, 0, 32768, 0, 0, 32768);
    send(8191, -8192);
    idle(4);
    chk("sat_re", last_re, 32767);
    chk("sat_im", last_im, -32768);
    chk("sat_flag_set", longint'(sat_flag), 1);
    chk("sat_count_one", longint'(sat_count), 1);
    send(8191, 0);
    idle(2);
    drv_clear = 1'b1;
    tick();
    chk("clear_and_event_flag", longint'(sat_flag), 1);
    chk("clear_and_event_count", longint'(sat_count), 1);
    drv_clear = 1'b1;
    tick();
    chk("clear_flag", longint'(sat_flag), 0);
    chk("clear_count", longint'(sat_count), 0);

    // Atomic coefficient switch in the middle of a ramp
    load(0, 0, 4096, 0, 0, 4096);
    for (int i = 0; i < 14; i++) begin
      if (i == 6) begin
        drv_b1 = 0; drv_b2 = 0;
        drv_a11 = 8192; drv_a12 = 0; drv_a21 = 0; drv_a22 = 8192;
        drv_load = 1'b1;
      end
      send(100 + i, -(100 + i));
    end
    idle(4);
    chk("ramp_last_re", last_re, 2 * 113);
    chk("ramp_last_im", last_im, -2 * 113);

    // Reset with three samples in flight
    load(0, 0, 4096, 0, 0, 4096);
    send(1, 2);
    send(3, 4);
    send(5, 6);
    drv_rst = 1'b1;
    tick();
    idle(5);

    // Bypass ignores the offset; the next corrected sample applies it
    load(300, -20, 4096, 0, 0, 4096);
    drv_byp = 1'b1;
    send(-8192, 5);
    drv_byp = 1'b0;
    idle(4);
    chk("bypass_re", last_re, -8192);
    chk("bypass_im", last_im, 5);
    send(-8192, 5);
    idle(4);
    chk("offset_re", last_re, -7892);
    chk("offset_im", last_im, -15);

    // Random traffic with random coefficient sets, mode changes and clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        drv_b1 = srand(-8192, 8191);
        drv_b2 = srand(-8192, 8191);
        if ($urandom_range(0, 3) == 0) begin
          drv_a11 = srand(-65536, 65536); drv_a12 = srand(-65536, 65536);
          drv_a21 = srand(-65536, 65536); drv_a22 = srand(-65536, 65536);
        end else begin
          drv_a11 = srand(-6000, 6000); drv_a12 = srand(-2000, 2000);
          drv_a21 = srand(-2000, 2000); drv_a22 = srand(-6000, 6000);
        end
        drv_load = 1'b1;
      end
      drv_clear = ($urandom_range(0, 19) == 0);
      drv_byp   = ($urandom_range(0, 3) == 0);
      drv_valid = ($urandom_range(0, 4) != 0);
      drv_re    = srand(-8192, 8191);
      drv_im    = srand(-8192, 8191);
      tick();
    end
    drv_byp = 1'b0;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iq_correction_sat.md
# iq_correction_sat

Pipelined, parametrised IQ imbalance/offset corrector placed between the ADC demodulation stage and the phase/lock processing chain. Applies a per-sample DC offset followed by a 2×2 fixed-point correction matrix, with rounding, output saturation and overflow monitoring. Coefficient updates are double-buffered and take effect atomically, so no sample is processed with a mix of old and new coefficients. A bypass mode passes samples through with identical latency.

## Interface

**Parameters**
- INPUT_WIDTH, 14, signed input sample width.
- OUTPUT_WIDTH, 16, signed output sample width.
- GAIN_WIDTH, 24, signed matrix coefficient width.
- GAIN_WIDTH_FRAC, 12, fractional bits of the coefficients; unity gain is 2^GAIN_WIDTH_FRAC.
- COUNT_WIDTH, 16, width of the saturation event counter.

**Ports**
- clk, in, 1, single clock for all logic.
- rst, in, 1, synchronous reset, active-high.
- in_valid, in, 1, input sample strobe.
- IQ_i_real, in, INPUT_WIDTH, signed real/I input.
- IQ_i_imag, in, INPUT_WIDTH, signed imag/Q input.
- Bvect1, in, INPUT_WIDTH, signed offset added to the real input.
- Bvect2, in, INPUT_WIDTH, signed offset added to the imag input.
- Amat11, Amat12, Amat21, Amat22, in, GAIN_WIDTH each, signed matrix coefficients.
- coef_load, in, 1, one-cycle strobe that captures Bvect1/2 and Amat into the active set.
- bypass, in, 1, 1 = output equals input, sign-extended.
- sat_clear, in, 1, clears sat_flag and sat_count.
- out_valid, out, 1, output sample strobe.
- IQ_o_real, out, OUTPUT_WIDTH, signed corrected real output.
- IQ_o_imag, out, OUTPUT_WIDTH, signed corrected imag output.
- sat_flag, out, 1, sticky: at least one output has been saturated.
- sat_count, out, COUNT_WIDTH, number of saturated output samples; holds at all-ones.

## Operation

- **Active coefficient set:** registered copy of B and A. Loaded only on a cycle with coef_load=1. On reset, B=0 and A=identity (A11=A22=2^FRAC, A12=A21=0).
- **Stage 1:**
  - Register the input.
  - re_c = IQ_i_real + B1 and im_c = IQ_i_imag + B2, each INPUT_WIDTH+1 bits wide, so the addition cannot wrap.
  - Latch the active A set into the stage-1 coefficient copy alongside the sample.
- **Stage 2:** four products, each INPUT_WIDTH+1+GAIN_WIDTH bits, using the stage-1 copy of A:
  - A11·re_c, A12·im_c, A21·re_c, A22·im_c.
- **Stage 3:**
  - out_re = A11·re_c + A12·im_c.
  - out_im = A21·re_c + A22·im_c.
  - Sums use full width plus 1 bit.
  - Add 2^(FRAC-1), then arithmetic-shift right by FRAC. This is round-half-up.
- **Stage 4:**
  - Saturate each value to [-2^(OW-1), 2^(OW-1)-1] and register it to the outputs.
  - Compute the per-sample saturation bit sat_s = (real saturated) OR (imag saturated).
- **Bypass:**
  - The bypass value is sampled at stage 1 and travels with the sample.
  - With bypass set, output = the raw input sign-extended to OW. No offset is applied and no saturation accounting is done.
  - If INPUT_WIDTH > OUTPUT_WIDTH, the bypass path saturates.
- **Valid handling:** in_valid travels through a 4-deep valid pipeline. Data registers advance every cycle. Outputs are meaningful only when out_valid=1.
- **Saturation monitor:** updated only on output cycles with out_valid=1 and sat_s=1.
  - sat_flag is set to 1.
  - sat_count increments and stays at all-ones once there.
- **sat_clear:**
  - Clears the flag and the counter.
  - If sat_clear and a saturation event happen in the same cycle, the result is sat_flag=1 and sat_count=1.
- **coef_load:**
  - Coefficients apply to samples accepted at stage 1 on the cycle after coef_load or later.
  - A sample accepted on the same cycle as coef_load uses the old set, for both B and A.

## Timing

- Latency is fixed at 4 cycles: a sample with in_valid at cycle N produces out_valid at N+4. This holds in both bypass and normal mode.
- Throughput is 1 sample per cycle. There is no back-pressure.
- Reset values:
  - out_valid=0, IQ_o_real=0, IQ_o_imag=0, sat_flag=0, sat_count=0.
  - Valid pipeline is cleared.
  - Active coefficients are set to identity/zero.
- Reset mid-stream drops all in-flight samples. There is no out_valid for them.
- Mode changes (bypass) take effect per sample with no glitch. Each output is fully bypassed or fully corrected, never mixed.

## Test plan

All scenarios use default parameters; unity gain = 4096.

1. **Identity:** after reset, in_valid with re=1000, im=-500 → out_valid 4 cycles later with 1000 and -500; sat_flag=0.
2. **Offset plus rotation:** load B1=-100, B2=50, A11=0, A12=4096, A21=4096, A22=0; input re=100, im=0 → out re=50, im=0.
3. **Rounding:** A11=A22=2048, others 0:
   - re=3 → 2; re=-3 → -1.
   - im=1 → 1; im=-1 → 0.
4. **Saturation:** A11=A22=32768; re=8191, im=-8192 → 32767 and -32768; sat_flag=1, sat_count=1.
   - Follow with sat_clear plus another saturating sample in the same cycle → sat_flag=1, sat_count=1.
5. **Atomic coefficient load:** continuous in_valid with a ramp input; coef_load switches identity to ×2 on cycle K.
   - Samples accepted at cycle ≤K give ×1; samples accepted at cycle >K give ×2.
   - No output mixes the two sets.
6. **Reset and bypass:**
   - Assert rst for 1 cycle with 3 samples in flight → no out_valid for them; outputs are 0.
   - Then bypass=1, re=-8192 → out -8192 at latency 4 with no offset applied.
